// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: opcode-driven format decode, sign-extended immediate
// and pc+imm target, registered behind a valid/ready handshake with a 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    FMT_I     = 3'd0,
    FMT_ISTAR = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_R     = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  // ---------------- combinational decode of the incoming instruction -------------
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_shift;
  fmt_e            w_fmt;
  logic            w_illegal;
  logic            w_shamt5;
  logic [XLEN-1:0] w_imm;
  entry_t          w_new;

  assign w_opcode   = in_inst[6:0];
  assign w_funct3   = in_inst[14:12];
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_fmt     = FMT_R;
    w_illegal = 1'b0;
    w_shamt5  = 1'b0;
    unique case (w_opcode)
      7'b0010011: w_fmt = w_is_shift ? FMT_ISTAR : FMT_I;
      7'b0000011,
      7'b1100111,
      7'b1110011,
      7'b0001111: w_fmt = FMT_I;
      7'b0100011: w_fmt = FMT_S;
      7'b1100011: w_fmt = FMT_B;
      7'b0110111,
      7'b0010111: w_fmt = FMT_U;
      7'b1101111: w_fmt = FMT_J;
      7'b0110011: w_fmt = FMT_R;
      7'b0011011: begin
        // RV64 word ops: shifts carry only a 5-bit shamt
        if (XLEN == 64) begin
          w_fmt    = w_is_shift ? FMT_ISTAR : FMT_I;
          w_shamt5 = w_is_shift;
        end else begin
          w_illegal = 1'b1;
        end
      end
      7'b0111011: begin
        if (XLEN != 64) w_illegal = 1'b1;
      end
      default:    w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_imm = '0;
    unique case (w_fmt)
      FMT_I:     w_imm = XLEN'(signed'(in_inst[31:20]));
      FMT_ISTAR: w_imm = w_shamt5 ? XLEN'(in_inst[24:20]) : XLEN'(in_inst[20 +: SHAMT_W]);
      FMT_S:     w_imm = XLEN'(signed'({in_inst[31:25], in_inst[11:7]}));
      FMT_B:     w_imm = XLEN'(signed'({in_inst[31], in_inst[7], in_inst[30:25],
                                        in_inst[11:8], 1'b0}));
      FMT_U:     w_imm = XLEN'(signed'({in_inst[31:12], 12'b0}));
      FMT_J:     w_imm = XLEN'(signed'({in_inst[31], in_inst[19:12], in_inst[20],
                                        in_inst[30:21], 1'b0}));
      default:   w_imm = '0;
    endcase
  end

  assign w_new = '{imm: w_imm, fmt: w_fmt, illegal: w_illegal,
                   pc: in_pc, target: in_pc + w_imm};

  // ---------------- main + skid buffer -----------------------------------------
  logic   r_main_valid;
  logic   r_skid_valid;
  entry_t r_main;
  entry_t r_skid;
  logic   w_in_fire;
  logic   w_out_fire;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_main_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '{imm: '0, fmt: FMT_I, illegal: 1'b0, pc: '0, target: '0};
      r_skid       <= '{imm: '0, fmt: FMT_I, illegal: 1'b0, pc: '0, target: '0};
    end else if (flush) begin
      // data registers keep their contents; only the valids are dropped
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_fire) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_main       <= w_new;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      if (!r_main_valid) begin
        r_main       <= w_new;
        r_main_valid <= 1'b1;
      end else begin
        r_skid       <= w_new;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign in_ready    = !r_skid_valid;
  assign out_valid   = r_main_valid;
  assign out_imm     = r_main.imm;
  assign out_type    = r_main.fmt;
  assign out_illegal = r_main.illegal;
  assign out_pc      = r_main.pc;
  assign out_target  = r_main.target;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe: XLEN=32 instance for function,
// handshake, flush and reset; XLEN=64 instance for wide-immediate formats.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;

  // XLEN=32 instance signals
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst, in_pc, out_imm, out_pc, out_target;
  logic [2:0]  out_type;

  // XLEN=64 instance signals
  logic        v_in_valid, v_in_ready, v_out_valid, v_out_illegal;
  logic [31:0] v_in_inst;
  logic [63:0] v_in_pc, v_out_imm, v_out_pc, v_out_target;
  logic [2:0]  v_out_type;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_type(out_type), .out_illegal(out_illegal), .out_pc(out_pc),
    .out_target(out_target)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(v_in_valid), .in_ready(v_in_ready), .in_inst(v_in_inst), .in_pc(v_in_pc),
    .out_valid(v_out_valid), .out_ready(1'b1), .out_imm(v_out_imm),
    .out_type(v_out_type), .out_illegal(v_out_illegal), .out_pc(v_out_pc),
    .out_target(v_out_target)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the edge, outputs are read at the same point
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  // one instruction with out_ready=1; result must appear exactly one cycle later
  task automatic send32(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] e_imm, input logic [2:0] e_type,
                        input logic e_ill, input logic [31:0] e_tgt);
    offer(inst, pc);
    step();
    check({tag, ".valid"},   64'(out_valid),   64'd1);
    check({tag, ".imm"},     64'(out_imm),     64'(e_imm));
    check({tag, ".type"},    64'(out_type),    64'(e_type));
    check({tag, ".illegal"}, 64'(out_illegal), 64'(e_ill));
    check({tag, ".pc"},      64'(out_pc),      64'(pc));
    check({tag, ".target"},  64'(out_target),  64'(e_tgt));
  endtask

  task automatic send64(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                        input logic [63:0] e_imm, input logic [2:0] e_type,
                        input logic [63:0] e_tgt);
    v_in_valid = 1'b1;
    v_in_inst  = inst;
    v_in_pc    = pc;
    step();
    v_in_valid = 1'b0;
    check({tag, ".valid"},  64'(v_out_valid), 64'd1);
    check({tag, ".imm"},    v_out_imm,        e_imm);
    check({tag, ".type"},   64'(v_out_type),  64'(e_type));
    check({tag, ".target"}, v_out_target,     e_tgt);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    v_in_valid = 1'b0; v_in_inst = '0; v_in_pc = '0;

    // ---- reset ----
    step(2);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_imm",   64'(out_imm),   64'd0);
    check("rst.target",    64'(out_target), 64'd0);
    check("rst64.valid",   64'(v_out_valid), 64'd0);
    rst = 1'b0;
    step();

    // ---- single result + format sweep, back to back ----
    send32("addi",  32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd0, 1'b0, 32'h000000FF);
    send32("slli",  32'h00309093, 32'h200, 32'h00000003, 3'd1, 1'b0, 32'h00000203);
    send32("sw",    32'hFE112E23, 32'h200, 32'hFFFFFFFC, 3'd2, 1'b0, 32'h000001FC);
    send32("beq",   32'hFE000CE3, 32'h100, 32'hFFFFFFF8, 3'd3, 1'b0, 32'h000000F8);
    send32("lui",   32'h123450B7, 32'h010, 32'h12345000, 3'd4, 1'b0, 32'h12345010);
    send32("jal",   32'h008000EF, 32'h100, 32'h00000008, 3'd5, 1'b0, 32'h00000108);
    send32("lw",    32'h00412083, 32'h040, 32'h00000004, 3'd0, 1'b0, 32'h00000044);
    send32("add",   32'h002081B3, 32'h050, 32'h00000000, 3'd6, 1'b0, 32'h00000050);
    send32("bad",   32'h0000007F, 32'h300, 32'h00000000, 3'd6, 1'b1, 32'h00000300);
    send32("w32",   32'h0000101B, 32'h300, 32'h00000000, 3'd6, 1'b1, 32'h00000300);
    in_valid = 1'b0;
    step();
    check("drain.out_valid", 64'(out_valid), 64'd0);

    // ---- backpressure: A main, B skid, C held upstream ----
    out_ready = 1'b0;
    offer(32'h00100093, 32'h0);
    step();
    check("bp.A.valid",    64'(out_valid), 64'd1);
    check("bp.A.imm",      64'(out_imm),   64'd1);
    check("bp.A.in_ready", 64'(in_ready),  64'd1);
    offer(32'h00200093, 32'h0);
    step();
    check("bp.B.in_ready", 64'(in_ready),  64'd0);
    check("bp.B.hold_imm", 64'(out_imm),   64'd1);
    offer(32'h00300093, 32'h0);
    step();
    check("bp.C.in_ready", 64'(in_ready),  64'd0);
    check("bp.C.hold_imm", 64'(out_imm),   64'd1);
    out_ready = 1'b1;
    step();
    check("bp.rel1.imm",      64'(out_imm),   64'd2);
    check("bp.rel1.in_ready", 64'(in_ready),  64'd1);
    step();
    check("bp.rel2.imm",   64'(out_imm),   64'd3);
    check("bp.rel2.valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step();
    check("bp.end.valid",  64'(out_valid), 64'd0);

    // ---- flush with both entries full and an input offered ----
    out_ready = 1'b0;
    offer(32'h00400093, 32'h0);
    step();
    offer(32'h00500093, 32'h0);
    step();
    check("fl.full.in_ready", 64'(in_ready), 64'd0);
    offer(32'h00600093, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.out_valid", 64'(out_valid), 64'd0);
    check("fl.in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step(2);
    check("fl.quiet", 64'(out_valid), 64'd0);
    send32("fl.next", 32'h00700093, 32'h10, 32'h7, 3'd0, 1'b0, 32'h17);
    in_valid = 1'b0;
    step();
    check("fl.next.drain", 64'(out_valid), 64'd0);

    // ---- mid-stream reset with an entry in skid ----
    out_ready = 1'b0;
    offer(32'h00800093, 32'h20);
    step();
    offer(32'h00900093, 32'h24);
    step();
    check("mr.skid.in_ready", 64'(in_ready), 64'd0);
    offer(32'h00A00093, 32'h28);
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("mr.out_valid", 64'(out_valid),   64'd0);
    check("mr.in_ready",  64'(in_ready),    64'd1);
    check("mr.imm",       64'(out_imm),     64'd0);
    check("mr.type",      64'(out_type),    64'd0);
    check("mr.illegal",   64'(out_illegal), 64'd0);
    check("mr.pc",        64'(out_pc),      64'd0);
    check("mr.target",    64'(out_target),  64'd0);
    out_ready = 1'b1;
    send32("mr.next", 32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd0, 1'b0, 32'hFF);
    in_valid = 1'b0;
    step();

    // ---- XLEN=64 instance ----
    send64("x64.addi", 32'hFFF00093, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 3'd0, 64'hFFF);
    send64("x64.lui",  32'h800000B7, 64'h0,    64'hFFFFFFFF80000000, 3'd4,
           64'hFFFFFFFF80000000);
    send64("x64.slli", 32'h03F09093, 64'h8,    64'd63, 3'd1, 64'd71);
    send64("x64.slliw", 32'h03F0909B, 64'h8,   64'd31, 3'd1, 64'd39);
    check("x64.slliw.illegal", 64'(v_out_illegal), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
